// File: rtl/pr_bitstream_feeder.sv
// Streams a stored partial-reconfiguration bitstream from a synchronous ROM into the PR controller.
// ROM read latency is hidden behind a credit-managed first-word-fall-through FIFO.
module pr_bitstream_feeder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              abort,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
    localparam logic [PTR_W-1:0]  P_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  C_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]    DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_nextState;
    logic [ADDR_W-1:0] r_addr, r_issueRem, r_wordCount, r_sentCnt;
    logic [ROM_LATENCY-1:0] r_pipe;
    logic [CNT_W-1:0]  r_fifoCnt, w_inflight;
    logic [CNT_W:0]    w_committed;
    logic [PTR_W-1:0]  r_wrPtr, r_rdPtr, w_rdPtrNext;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] r_outData, w_nextHead;
    logic              r_error;
    logic              w_idle, w_accept, w_zeroStart, w_abort, w_issue, w_ret, w_pop;

    assign w_idle      = (r_state == S_IDLE);
    assign w_accept    = w_idle && start && (word_count != '0);
    assign w_zeroStart = w_idle && start && (word_count == '0);
    assign w_abort     = abort && !w_idle;
    assign w_ret       = r_pipe[ROM_LATENCY-1];
    assign w_pop       = out_valid && out_ready;

    // A read may only be issued while queued plus in-flight words leave a free FIFO slot.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_pipe[i]);
        end
    end

    assign w_committed = {1'b0, r_fifoCnt} + {1'b0, w_inflight};
    assign w_issue     = (r_state == S_FETCH) && (r_issueRem != '0) && (w_committed < DEPTH_V);

    assign rom_rd    = w_issue;
    assign rom_addr  = r_addr;
    assign out_data  = r_outData;
    assign out_valid = (r_fifoCnt != '0);
    assign out_last  = out_valid && ((r_sentCnt + A_ONE) == r_wordCount);
    assign error     = r_error;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_nextState = S_FETCH;
            end
            S_FETCH: begin
                busy = 1'b1;
                if (w_issue && (r_issueRem == A_ONE)) w_nextState = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_pop && out_last) w_nextState = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
        if (w_abort) w_nextState = S_IDLE;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_addr      <= '0;
            r_issueRem  <= '0;
            r_wordCount <= '0;
            r_sentCnt   <= '0;
            r_error     <= 1'b0;
        end else begin
            r_error <= w_abort || w_zeroStart;
            if (w_accept) begin
                r_addr      <= base_addr;
                r_issueRem  <= word_count;
                r_wordCount <= word_count;
                r_sentCnt   <= '0;
            end else begin
                if (w_issue) begin
                    r_addr     <= r_addr + A_ONE;
                    r_issueRem <= r_issueRem - A_ONE;
                end
                if (w_pop) r_sentCnt <= r_sentCnt + A_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pipe <= '0;
        end else if (w_abort) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_issue;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // The registered head takes the returning word directly when the FIFO would otherwise be empty.
    always_comb begin
        w_rdPtrNext = r_rdPtr + PTR_W'(w_pop);
        w_nextHead  = r_outData;
        if ((r_fifoCnt == '0) || ((r_fifoCnt == C_ONE) && w_pop)) begin
            if (w_ret) w_nextHead = rom_rdata;
        end else begin
            w_nextHead = r_mem[w_rdPtrNext];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_fifoCnt <= '0;
            r_outData <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_abort) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_fifoCnt <= '0;
            r_outData <= '0;
        end else begin
            if (w_ret) begin
                r_mem[r_wrPtr] <= rom_rdata;
                r_wrPtr        <= r_wrPtr + P_ONE;
            end
            r_rdPtr <= w_rdPtrNext;
            case ({w_ret, w_pop})
                2'b10:   r_fifoCnt <= r_fifoCnt + C_ONE;
                2'b01:   r_fifoCnt <= r_fifoCnt - C_ONE;
                default: r_fifoCnt <= r_fifoCnt;
            endcase
            r_outData <= w_nextHead;
        end
    end

endmodule

// File: tb/tb_pr_bitstream_feeder.sv
// Directed bench for pr_bitstream_feeder: main instance at ROM_LATENCY=2 plus latency-1 and latency-4 instances.
// Each instance has a behavioural synchronous ROM whose word is a fixed function of the address.
module tb_pr_bitstream_feeder;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start, start1, start4;
    logic [15:0] base_addr, word_count;
    logic        abort;
    logic        out_ready;

    logic        rom_rd, rom_rd1, rom_rd4;
    logic [15:0] rom_addr, rom_addr1, rom_addr4;
    logic [15:0] rom_rdata, rom_rdata1, rom_rdata4;
    logic [15:0] out_data, out_data1, out_data4;
    logic        out_valid, out_valid1, out_valid4;
    logic        out_last, out_last1, out_last4;
    logic        busy, busy1, busy4;
    logic        done, done1, done4;
    logic        error, error1, error4;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] romData(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    pr_bitstream_feeder #(.DATA_W(16), .ADDR_W(16), .ROM_LATENCY(2), .FIFO_DEPTH(8)) dut (
        .clk(clk), .nreset(nreset), .start(start), .base_addr(base_addr), .word_count(word_count),
        .abort(abort), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done), .error(error));

    pr_bitstream_feeder #(.DATA_W(16), .ADDR_W(16), .ROM_LATENCY(1), .FIFO_DEPTH(8)) dutL1 (
        .clk(clk), .nreset(nreset), .start(start1), .base_addr(base_addr), .word_count(word_count),
        .abort(1'b0), .rom_rd(rom_rd1), .rom_addr(rom_addr1), .rom_rdata(rom_rdata1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(1'b1), .out_last(out_last1),
        .busy(busy1), .done(done1), .error(error1));

    pr_bitstream_feeder #(.DATA_W(16), .ADDR_W(16), .ROM_LATENCY(4), .FIFO_DEPTH(8)) dutL4 (
        .clk(clk), .nreset(nreset), .start(start4), .base_addr(base_addr), .word_count(word_count),
        .abort(1'b0), .rom_rd(rom_rd4), .rom_addr(rom_addr4), .rom_rdata(rom_rdata4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(1'b1), .out_last(out_last4),
        .busy(busy4), .done(done4), .error(error4));

    // Behavioural ROMs: the address captured on a read strobe emerges ROM_LATENCY cycles later.
    logic [15:0] romPipe [2];
    logic [15:0] romPipe1;
    logic [15:0] romPipe4 [4];

    always @(posedge clk) begin
        romPipe[0]  <= rom_rd ? rom_addr : 16'h0000;
        romPipe[1]  <= romPipe[0];
        romPipe1    <= rom_rd1 ? rom_addr1 : 16'h0000;
        romPipe4[0] <= rom_rd4 ? rom_addr4 : 16'h0000;
        for (int i = 1; i < 4; i++) romPipe4[i] <= romPipe4[i-1];
    end

    assign rom_rdata  = romData(romPipe[1]);
    assign rom_rdata1 = romData(romPipe1);
    assign rom_rdata4 = romData(romPipe4[3]);

    // Monitor of the main instance, sampled on the active edge with pre-edge values.
    logic [15:0] romQ [$];
    logic [15:0] dataQ [$];
    logic        lastQ [$];
    int          cyc = 0, lastAcc = 0, doneCyc = 0;
    int          doneCnt = 0, errorCnt = 0, done1Cnt = 0, done4Cnt = 0;
    int          outstanding = 0, maxOut = 0, stallViol = 0;
    logic        prevStall = 1'b0;
    logic [15:0] prevData = '0;
    logic        prevLast = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rom_rd) romQ.push_back(rom_addr);
        if (out_valid && out_ready) begin
            dataQ.push_back(out_data);
            lastQ.push_back(out_last);
            lastAcc = cyc;
        end
        if (done) begin doneCnt++; doneCyc = cyc; end
        if (error) errorCnt++;
        if (done1) done1Cnt++;
        if (done4) done4Cnt++;
        outstanding = outstanding + int'(rom_rd) - int'(out_valid && out_ready);
        if (outstanding > maxOut) maxOut = outstanding;
        if (prevStall && (out_data !== prevData || out_last !== prevLast)) stallViol++;
        prevStall = out_valid && !out_ready;
        prevData  = out_data;
        prevLast  = out_last;
    end

    task automatic clearMon();
        romQ.delete(); dataQ.delete(); lastQ.delete();
        outstanding = 0; maxOut = 0; stallViol = 0;
    endtask

    task automatic pulseStart(input logic [15:0] b, input logic [15:0] n);
        base_addr = b; word_count = n;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic waitDone(input int d0, input int maxCyc);
        for (int i = 0; i < maxCyc && doneCnt == d0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        nreset = 1'b0; start = 0; start1 = 0; start4 = 0; abort = 0; out_ready = 1;
        base_addr = '0; word_count = '0;
        repeat (3) @(negedge clk);
        assertions++;
        if ({rom_rd, rom_addr, out_data, out_valid, out_last, busy, done, error} !== 38'd0) begin
            failures++; $display("[TB] FAIL reset_outputs: got %h required 0",
                {rom_rd, rom_addr, out_data, out_valid, out_last, busy, done, error});
        end
        nreset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int d0;
        clearMon(); d0 = doneCnt; out_ready = 1;
        pulseStart(16'h0010, 16'd5);
        waitDone(d0, 100);
        assertions++;
        if (romQ.size() != 5) begin failures++; $display("[TB] FAIL basic_reads: got %0d required 5", romQ.size()); end
        for (int i = 0; i < romQ.size(); i++) begin
            assertions++;
            if (romQ[i] !== 16'h0010 + 16'(i)) begin failures++; $display("[TB] FAIL basic_addr[%0d]: got %h required %h", i, romQ[i], 16'h0010 + 16'(i)); end
        end
        assertions++;
        if (dataQ.size() != 5) begin failures++; $display("[TB] FAIL basic_words: got %0d required 5", dataQ.size()); end
        for (int i = 0; i < dataQ.size(); i++) begin
            assertions++;
            if (dataQ[i] !== romData(16'h0010 + 16'(i)) || lastQ[i] !== (i == 4)) begin
                failures++; $display("[TB] FAIL basic_word[%0d]: got %h/%b required %h/%b", i, dataQ[i], lastQ[i], romData(16'h0010 + 16'(i)), (i == 4));
            end
        end
        assertions++;
        if (doneCnt != d0 + 1 || doneCyc != lastAcc + 1) begin
            failures++; $display("[TB] FAIL basic_done: got count %0d at cyc %0d required count %0d at cyc %0d", doneCnt - d0, doneCyc, 1, lastAcc + 1);
        end
        assertions++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_after: got %b required 0", busy); end
    endtask

    task automatic test_backpressure();
        int d0;
        clearMon(); d0 = doneCnt; out_ready = 0;
        pulseStart(16'h0100, 16'd20);
        for (int i = 0; i < 400 && doneCnt == d0; i++) begin
            out_ready = (i % 4 == 0);
            @(negedge clk);
        end
        out_ready = 1;
        repeat (3) @(negedge clk);
        assertions++;
        if (dataQ.size() != 20) begin failures++; $display("[TB] FAIL bp_words: got %0d required 20", dataQ.size()); end
        for (int i = 0; i < dataQ.size(); i++) begin
            assertions++;
            if (dataQ[i] !== romData(16'h0100 + 16'(i)) || lastQ[i] !== (i == 19)) begin
                failures++; $display("[TB] FAIL bp_word[%0d]: got %h/%b required %h/%b", i, dataQ[i], lastQ[i], romData(16'h0100 + 16'(i)), (i == 19));
            end
        end
        assertions++;
        if (maxOut > 8) begin failures++; $display("[TB] FAIL bp_credit: got %0d outstanding required at most 8", maxOut); end
        assertions++;
        if (stallViol != 0) begin failures++; $display("[TB] FAIL bp_stable: got %0d changes while stalled required 0", stallViol); end
        assertions++;
        if (doneCnt != d0 + 1) begin failures++; $display("[TB] FAIL bp_done: got %0d required 1", doneCnt - d0); end
    endtask

    task automatic test_wrap();
        int d0;
        logic [15:0] expAddr [4];
        expAddr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        clearMon(); d0 = doneCnt; out_ready = 1;
        pulseStart(16'hFFFE, 16'd4);
        waitDone(d0, 100);
        assertions++;
        if (romQ.size() != 4 || dataQ.size() != 4) begin failures++; $display("[TB] FAIL wrap_sizes: got %0d/%0d required 4/4", romQ.size(), dataQ.size()); end
        for (int i = 0; i < 4 && i < romQ.size() && i < dataQ.size(); i++) begin
            assertions++;
            if (romQ[i] !== expAddr[i] || dataQ[i] !== romData(expAddr[i]) || lastQ[i] !== (i == 3)) begin
                failures++; $display("[TB] FAIL wrap_word[%0d]: got %h/%h/%b required %h/%h/%b", i, romQ[i], dataQ[i], lastQ[i], expAddr[i], romData(expAddr[i]), (i == 3));
            end
        end
    endtask

    task automatic test_zero_and_busy_start();
        int d0, e0;
        clearMon(); d0 = doneCnt; e0 = errorCnt; out_ready = 1;
        pulseStart(16'h0200, 16'd0);
        assertions++;
        if (error !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL zero_error: got err %b busy %b required 1 0", error, busy); end
        @(negedge clk);
        assertions++;
        if (error !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL zero_pulse_end: got err %b busy %b required 0 0", error, busy); end
        pulseStart(16'h0200, 16'd10);
        repeat (2) @(negedge clk);
        pulseStart(16'h0300, 16'd3);
        waitDone(d0, 100);
        assertions++;
        if (dataQ.size() != 10 || romQ.size() != 10) begin failures++; $display("[TB] FAIL busy_start_words: got %0d/%0d required 10/10", dataQ.size(), romQ.size()); end
        for (int i = 0; i < dataQ.size() && i < romQ.size(); i++) begin
            assertions++;
            if (romQ[i] !== 16'h0200 + 16'(i) || dataQ[i] !== romData(16'h0200 + 16'(i)) || lastQ[i] !== (i == 9)) begin
                failures++; $display("[TB] FAIL busy_start_word[%0d]: got %h/%h/%b required %h/%h/%b", i, romQ[i], dataQ[i], lastQ[i], 16'h0200 + 16'(i), romData(16'h0200 + 16'(i)), (i == 9));
            end
        end
        assertions++;
        if (errorCnt != e0 + 1 || doneCnt != d0 + 1) begin failures++; $display("[TB] FAIL zero_busy_status: got err %0d done %0d required 1 1", errorCnt - e0, doneCnt - d0); end
    endtask

    task automatic test_abort();
        int d0, e0, r0;
        clearMon(); d0 = doneCnt; e0 = errorCnt; out_ready = 1;
        pulseStart(16'h0400, 16'd100);
        for (int i = 0; i < 200 && dataQ.size() < 30; i++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        assertions++;
        if (out_valid !== 1'b0 || error !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL abort_next: got valid %b err %b busy %b required 0 1 0", out_valid, error, busy);
        end
        r0 = romQ.size();
        repeat (10) @(negedge clk);
        assertions++;
        if (romQ.size() != r0) begin failures++; $display("[TB] FAIL abort_reads: got %0d required %0d", romQ.size(), r0); end
        assertions++;
        if (doneCnt != d0 || errorCnt != e0 + 1) begin failures++; $display("[TB] FAIL abort_status: got done %0d err %0d required 0 1", doneCnt - d0, errorCnt - e0); end
        assertions++;
        if (dataQ.size() < 30 || dataQ.size() > 31) begin failures++; $display("[TB] FAIL abort_count: got %0d required 30..31", dataQ.size()); end
        for (int i = 0; i < dataQ.size(); i++) begin
            assertions++;
            if (dataQ[i] !== romData(16'h0400 + 16'(i)) || lastQ[i] !== 1'b0) begin
                failures++; $display("[TB] FAIL abort_word[%0d]: got %h/%b required %h/0", i, dataQ[i], lastQ[i], romData(16'h0400 + 16'(i)));
            end
        end
        clearMon(); d0 = doneCnt;
        pulseStart(16'h0500, 16'd3);
        waitDone(d0, 100);
        assertions++;
        if (dataQ.size() != 3 || doneCnt != d0 + 1) begin failures++; $display("[TB] FAIL restart_words: got %0d done %0d required 3 1", dataQ.size(), doneCnt - d0); end
        for (int i = 0; i < dataQ.size(); i++) begin
            assertions++;
            if (dataQ[i] !== romData(16'h0500 + 16'(i)) || lastQ[i] !== (i == 2)) begin
                failures++; $display("[TB] FAIL restart_word[%0d]: got %h/%b required %h/%b", i, dataQ[i], lastQ[i], romData(16'h0500 + 16'(i)), (i == 2));
            end
        end
    endtask

    task automatic test_latency();
        int n, d0;
        logic [15:0] first1, first4;
        d0 = doneCnt; out_ready = 1; base_addr = 16'h0700; word_count = 16'd3;
        @(negedge clk); start = 1'b1; n = 0;
        do begin @(negedge clk); start = 1'b0; n++; end while (!out_valid && n < 20);
        assertions++;
        if (n != 4) begin failures++; $display("[TB] FAIL latency_L2: got %0d required 4", n); end
        waitDone(d0, 50);
        @(negedge clk); start1 = 1'b1; n = 0;
        do begin @(negedge clk); start1 = 1'b0; n++; end while (!out_valid1 && n < 20);
        first1 = out_data1;
        assertions++;
        if (n != 3 || first1 !== romData(16'h0700)) begin failures++; $display("[TB] FAIL latency_L1: got %0d/%h required 3/%h", n, first1, romData(16'h0700)); end
        @(negedge clk); start4 = 1'b1; n = 0;
        do begin @(negedge clk); start4 = 1'b0; n++; end while (!out_valid4 && n < 20);
        first4 = out_data4;
        assertions++;
        if (n != 6 || first4 !== romData(16'h0700)) begin failures++; $display("[TB] FAIL latency_L4: got %0d/%h required 6/%h", n, first4, romData(16'h0700)); end
        repeat (10) @(negedge clk);
        assertions++;
        if ({busy1, error1, out_valid1, out_last1, busy4, error4, out_valid4, out_last4} !== 8'd0 || done1Cnt != 1 || done4Cnt != 1) begin
            failures++; $display("[TB] FAIL latency_finish: got %b done %0d/%0d required 0 done 1/1",
                {busy1, error1, out_valid1, out_last1, busy4, error4, out_valid4, out_last4}, done1Cnt, done4Cnt);
        end
    endtask

    task automatic test_reset_mid();
        int d0, e0;
        clearMon(); out_ready = 1;
        pulseStart(16'h0600, 16'd50);
        repeat (8) @(negedge clk);
        d0 = doneCnt; e0 = errorCnt;
        nreset = 1'b0;
        #1;
        assertions++;
        if ({rom_rd, rom_addr, out_data, out_valid, out_last, busy, done, error} !== 38'd0) begin
            failures++; $display("[TB] FAIL reset_mid_outputs: got %h required 0",
                {rom_rd, rom_addr, out_data, out_valid, out_last, busy, done, error});
        end
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (10) @(negedge clk);
        assertions++;
        if (doneCnt != d0 || errorCnt != e0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_mid_quiet: got done %0d err %0d busy %b valid %b required 0 0 0 0", doneCnt - d0, errorCnt - e0, busy, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_and_busy_start();
        test_abort();
        test_latency();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/pr_bitstream_feeder.md
Name: pr_bitstream_feeder

Overview:
- Streams a stored partial-reconfiguration bitstream from on-chip memory into the PR controller's 16-bit data input.
- Sits directly upstream of the reconfig controller and consumes from a synchronous ROM/RAM read port.
- Hides ROM read latency behind a small credit-managed FIFO.
- Presents a valid/ready stream with a last-word marker, plus done and error status.

Parameters:
- DATA_W, 16: width of stream and ROM data words.
- ADDR_W, 16: ROM address width and word_count width.
- ROM_LATENCY, 2: fixed cycles from rom_rd to valid rom_rdata; legal range 1..4.
- FIFO_DEPTH, 8: output FIFO entries; power of two, at least ROM_LATENCY+1.

Ports:
- clk  in  1  single clock, shared with the PR controller.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a transfer; ignored unless idle.
- base_addr  in  ADDR_W  first ROM word address; sampled on accepted start.
- word_count  in  ADDR_W  number of words to send; sampled on accepted start.
- abort  in  1  pulse that cancels the transfer (driven from PR controller error or freeze logic).
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM read address.
- rom_rdata  in  DATA_W  ROM data, valid ROM_LATENCY cycles after rom_rd.
- out_data  out  DATA_W  stream word to the PR controller.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  PR controller accepts the word.
- out_last  out  1  current out_data is the final word.
- busy  out  1  high from accepted start until done, error or abort completes.
- done  out  1  one-cycle pulse after the last word is accepted.
- error  out  1  one-cycle pulse on zero-length start or abort.

Behaviour:
- Reset (nreset=0, async): all outputs 0. FSM goes to IDLE, FIFO empties, in-flight tracking clears, address and count registers clear.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start=1 with word_count!=0: latch base_addr and word_count, set busy, go to FETCH.
  - start=1 with word_count==0: error=1 for one cycle, stay IDLE, busy stays 0.
- FETCH:
  - rom_rd=1 in any cycle where issued_remaining>0 and (fifo_count + inflight) < FIFO_DEPTH.
  - rom_addr = base + issued index; it increments once per issued read and wraps modulo 2^ADDR_W.
  - Track in-flight reads with a ROM_LATENCY-deep valid shift register. A return writes rom_rdata into the FIFO in the cycle it is valid.
  - Credit rule: the FIFO never overflows, and no return is ever dropped except on abort.
  - When the last read is issued, go to DRAIN.
- DRAIN: no more reads. Go to DONE when out_valid & out_ready & out_last.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE. A start in this cycle is ignored.
- Stream rules:
  - out_valid = FIFO not empty.
  - out_data is the FIFO head, from a registered read (first-word fall-through).
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - A word transfers on out_valid & out_ready.
  - out_last=1 exactly on word number word_count (1-based). Use a separate sent counter; do not derive it from FIFO state.
- Minimum latency: accepted start to first out_valid = ROM_LATENCY+2 cycles (1 cycle to FETCH, 1 cycle for rom_rd, ROM_LATENCY cycles for data, FIFO head visible the same cycle as the write registers).
- Throughput: with out_ready held high, one word per cycle in steady state.
- Simultaneous FIFO write and read: allowed at any occupancy, including full with a read pending.
- abort (any state except IDLE):
  - Next cycle: FIFO flushed, in-flight returns discarded, out_valid=0, busy=0, error=1 for one cycle, FSM to IDLE.
  - abort in IDLE: no effect.
  - abort has priority over a same-cycle final handshake: error is raised and done is not.
- Reset mid-transfer: same state as power-up. No done or error pulse is emitted.

Test Plan:
- Basic transfer: base=0x0010, count=5, out_ready=1 -> ROM addresses 0x10..0x14 read in order; 5 words match ROM contents; out_last on word 5 only; done pulse one cycle after; busy low afterwards.
- Backpressure: count=20, out_ready toggles 1 cycle on / 3 cycles off -> never more than 8 entries held or in flight; no word lost or duplicated; data stable while stalled; done after word 20.
- Address wrap: base=0xFFFE, count=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; out_last on the 4th word.
- Zero length and busy start: start with count=0 -> error pulse, busy stays 0; start during an active count=10 transfer -> ignored, exactly 10 words sent.
- Abort: count=100, abort after 30 accepted words -> out_valid=0 and error pulse next cycle, no done, no further rom_rd; a new start with count=3 then sends 3 correct words.
- Latency and reset: ROM_LATENCY=1 and 4 variants, first out_valid exactly ROM_LATENCY+2 cycles after start; nreset pulsed mid-transfer -> all outputs 0 immediately, no done or error pulse.
